ps2_tx_multi: RTL and testbench

- Multi-channel PS/2 device-side transmitter: replaces the fixed keyboard/mouse pair of PS/2 emitters in the 8-bit core I/O block with CHANNELS identical lanes.
- Bytes arrive on one strobe bus in the clk_sys domain, are queued in per-channel FIFOs, and are serialised as 11-bit PS/2 frames.
- New over the previous generation: full detection with drop and sticky overflow, and host-inhibit detection with abort and whole-frame retransmit.

---
 rtl/ps2_tx_pkg.sv | 28 ++
 rtl/ps2_tx_lane.sv | 149 ++++++++++++++
 rtl/ps2_tx_multi.sv | 75 +++++++
 tb/tb_ps2_tx_multi.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_tx_pkg.sv
// Shared types and constants for the multi-channel PS/2 device-side transmitter.
package ps2_tx_pkg;

   localparam int unsigned FRAME_LEN  = 11;
   localparam int unsigned SYNC_DEPTH = 2;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      START   = 4'd1,
      D0      = 4'd2,
      D1      = 4'd3,
      D2      = 4'd4,
      D3      = 4'd5,
      D4      = 4'd6,
      D5      = 4'd7,
      D6      = 4'd8,
      D7      = 4'd9,
      PAR     = 4'd10,
      STOP    = 4'd11,
      INHIBIT = 4'd12
   } state_t;

   // States in which a host pull-down aborts the frame (STOP is allowed to finish)
   function automatic logic abortable(input state_t s);
      return (s >= START) && (s <= PAR);
   endfunction

endpackage

// File: rtl/ps2_tx_lane.sv
// One PS/2 transmit lane: byte FIFO, clock-line synchroniser, framing FSM.
// Optional drop/retransmit counters under PS2_TX_STATS_EN.
module ps2_tx_lane
   import ps2_tx_pkg::*;
#(
   parameter int unsigned FIFO_BITS = 3
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       tick,
   input  logic       phase,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       ovf_clear,
   input  logic       ps2_clk_in,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       fifo_full,
   output logic       overflow,
   output logic       busy
`ifdef PS2_TX_STATS_EN
   ,
   output logic [7:0] drop_cnt,
   output logic [7:0] retx_cnt
`endif
);

   localparam int unsigned DEPTH = 2**FIFO_BITS;

   logic [7:0]            mem [DEPTH];
   logic [FIFO_BITS-1:0]  wptr, rptr;
   logic [SYNC_DEPTH-1:0] sync;
   logic                  empty, full, push, drop, pop;
   logic                  clk_hi, host_low, abort, start_ok;
   state_t                state, state_n;
   logic [7:0]            shift, shift_n;
   logic                  parity, parity_n, data_n;

   assign empty    = (wptr == rptr);
   assign full     = (FIFO_BITS'(wptr + 1'b1) == rptr);
   assign push     = wr_en & ~full;
   assign drop     = wr_en & full;
   assign clk_hi   = sync[SYNC_DEPTH-1];
   assign host_low = ~clk_hi & phase;
   assign abort    = host_low & abortable(state);
   assign start_ok = ~empty & ~host_low;

   assign ps2_clk   = phase | (state == IDLE) | (state == INHIBIT);
   assign busy      = (state != IDLE) | ~empty;
   assign fifo_full = full;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) sync <= '1;
      else       sync <= {sync[SYNC_DEPTH-2:0], ps2_clk_in};
   end

   always_ff @(posedge clk_sys) begin
      if (push) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         wptr     <= wptr + FIFO_BITS'(push);
         rptr     <= rptr + FIFO_BITS'(pop);
         overflow <= drop | (overflow & ~ovf_clear);
      end
   end

   // State register, with the serialiser datapath that follows it
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         shift    <= '0;
         parity   <= 1'b0;
         ps2_data <= 1'b1;
      end else begin
         state    <= state_n;
         shift    <= shift_n;
         parity   <= parity_n;
         ps2_data <= data_n;
      end
   end

   // Next state: abort is checked every cycle, everything else waits for tick
   always_comb begin
      state_n = state;
      if (abort) begin
         state_n = INHIBIT;
      end else if (tick) begin
         case (state)
            IDLE:    if (start_ok) state_n = START;
            START, D0, D1, D2, D3, D4, D5, D6, D7, PAR:
                     state_n = state_t'(state + 4'd1);
            STOP:    state_n = IDLE;
            INHIBIT: if (clk_hi) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // Outputs: the line value for the state being entered, and the pop at frame end
   always_comb begin
      shift_n  = shift;
      parity_n = parity;
      data_n   = ps2_data;
      pop      = 1'b0;
      if (abort) begin
         data_n = 1'b1;
      end else if (tick) begin
         case (state)
            IDLE: if (start_ok) begin
               shift_n  = mem[rptr];
               parity_n = 1'b1;
               data_n   = 1'b0;
            end
            START, D0, D1, D2, D3, D4, D5, D6: begin
               data_n   = shift[0];
               shift_n  = {1'b0, shift[7:1]};
               parity_n = parity ^ shift[0];
            end
            D7:   data_n = parity;
            PAR:  data_n = 1'b1;
            STOP: begin
               data_n = 1'b1;
               pop    = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef PS2_TX_STATS_EN
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         drop_cnt <= '0;
         retx_cnt <= '0;
      end else begin
         if (drop) drop_cnt <= ovf_clear ? 8'd1 : ((drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1);
         else if (ovf_clear) drop_cnt <= '0;
         if (abort && (retx_cnt != 8'hFF)) retx_cnt <= retx_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: rtl/ps2_tx_multi.sv
// Multi-channel PS/2 transmitter: shared clock divider, write decode, CHANNELS lanes.
// Define PS2_TX_STATS_EN to add the drop_cnt / retx_cnt counter outputs.
module ps2_tx_multi
   import ps2_tx_pkg::*;
#(
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned FIFO_BITS = 3,
   parameter int unsigned PS2DIV    = 100
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  wr_strobe,
   input  logic [2:0]            wr_chan,
   input  logic [7:0]            wr_data,
   input  logic                  ovf_clear,
   input  logic [CHANNELS-1:0]   ps2_clk_in,
   output logic [CHANNELS-1:0]   ps2_clk,
   output logic [CHANNELS-1:0]   ps2_data,
   output logic [CHANNELS-1:0]   fifo_full,
   output logic [CHANNELS-1:0]   overflow,
   output logic [CHANNELS-1:0]   busy
`ifdef PS2_TX_STATS_EN
   ,
   output logic [CHANNELS*8-1:0] drop_cnt,
   output logic [CHANNELS*8-1:0] retx_cnt
`endif
);

   localparam int unsigned DIV_W = (PS2DIV > 0) ? $clog2(PS2DIV + 1) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic             phase, tick;

   // tick is high for the first clk_sys cycle of each high phase
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         phase   <= 1'b0;
         tick    <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (div_cnt == DIV_W'(PS2DIV)) begin
            div_cnt <= '0;
            phase   <= ~phase;
            tick    <= ~phase;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      ps2_tx_lane #(.FIFO_BITS(FIFO_BITS)) u_lane (
         .clk_sys    (clk_sys),
         .reset      (reset),
         .tick       (tick),
         .phase      (phase),
         .wr_en      (wr_strobe && (wr_chan == 3'(i))),
         .wr_data    (wr_data),
         .ovf_clear  (ovf_clear),
         .ps2_clk_in (ps2_clk_in[i]),
         .ps2_clk    (ps2_clk[i]),
         .ps2_data   (ps2_data[i]),
         .fifo_full  (fifo_full[i]),
         .overflow   (overflow[i]),
         .busy       (busy[i])
`ifdef PS2_TX_STATS_EN
         ,
         .drop_cnt   (drop_cnt[i*8 +: 8]),
         .retx_cnt   (retx_cnt[i*8 +: 8])
`endif
      );
   end

endmodule

// File: tb/tb_ps2_tx_multi.sv
// Directed bench for ps2_tx_multi (CHANNELS=2, FIFO_BITS=2, PS2DIV=3).
// Frames are captured at each falling ps2_clk edge as {stop, parity, byte, start}.
module tb_ps2_tx_multi;
   import ps2_tx_pkg::*;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        wr_strobe;
   logic [2:0]  wr_chan;
   logic [7:0]  wr_data;
   logic        ovf_clear;
   logic [1:0]  ps2_clk_in;
   logic [1:0]  ps2_clk, ps2_data, fifo_full, overflow, busy;
`ifdef PS2_TX_STATS_EN
   logic [15:0] drop_cnt, retx_cnt;
`endif

   int n_checks = 0;
   int n_err    = 0;

   ps2_tx_multi #(.CHANNELS(2), .FIFO_BITS(2), .PS2DIV(3)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .wr_strobe  (wr_strobe),
      .wr_chan    (wr_chan),
      .wr_data    (wr_data),
      .ovf_clear  (ovf_clear),
      .ps2_clk_in (ps2_clk_in),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .busy       (busy)
`ifdef PS2_TX_STATS_EN
      ,
      .drop_cnt   (drop_cnt),
      .retx_cnt   (retx_cnt)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] ch, input logic [7:0] d);
      wr_chan   = ch;
      wr_data   = d;
      wr_strobe = 1'b1;
      @(negedge clk_sys);
      wr_strobe = 1'b0;
   endtask

   // Return on the negedge inside the cycle where the divider tick is high
   task automatic sync_tick();
      bit got;
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk_sys);
         if (dut.tick === 1'b1) got = 1'b1;
      end
      if (!got) check("tick_timeout", 32'd0, 32'd1);
   endtask

   task automatic next_fall(input int ch, output int waited);
      logic prev;
      prev   = ps2_clk[ch];
      waited = -1;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk_sys);
         if (prev && !ps2_clk[ch]) begin
            waited = n;
            break;
         end
         prev = ps2_clk[ch];
      end
      if (waited < 0) check("ps2_clk_fall_timeout", 32'd0, 32'd1);
   endtask

   task automatic cap(input int ch, output logic [10:0] f0, output logic [10:0] f1,
                      output int span, output int misalign);
      int w;
      f0 = '0; f1 = '0; span = 0; misalign = 0;
      for (int k = 0; k < int'(FRAME_LEN); k++) begin
         next_fall(ch, w);
         if (w < 0) return;
         if (k > 0) span += w;
         f0[k] = ps2_data[0];
         f1[k] = ps2_data[1];
         if (ps2_clk[0] !== ps2_clk[1]) misalign++;
      end
   endtask

   task automatic wait_idle(input int ch);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk_sys);
         if (busy[ch] === 1'b0) got = 1'b1;
      end
      check("busy_falls", 32'(got), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] f0, f1;
      int span, mis, lat, lows;

      reset = 1'b1; wr_strobe = 1'b0; wr_chan = '0; wr_data = '0;
      ovf_clear = 1'b0; ps2_clk_in = 2'b11;
      repeat (3) @(negedge clk_sys);
      check("rst_ps2_clk",   32'(ps2_clk),   32'h3);
      check("rst_ps2_data",  32'(ps2_data),  32'h3);
      check("rst_fifo_full", 32'(fifo_full), 32'h0);
      check("rst_overflow",  32'(overflow),  32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);

      // 0xA5 on ch0
      wr(3'd0, 8'hA5);
      lat = 0;
      while (ps2_data[0] !== 1'b0 && lat < 30) begin @(negedge clk_sys); lat++; end
      check("start_latency_le_10", 32'(lat <= 10), 32'd1);
      cap(0, f0, f1, span, mis);
      check("frame_a5", 32'(f0), 32'h74A);
      check("clk_period_span", 32'(span), 32'd80);
      repeat (6) @(negedge clk_sys);
      lows = 0;
      for (int n = 0; n < 16; n++) begin @(negedge clk_sys); if (!ps2_clk[0]) lows++; end
      check("clk_idle_high", 32'(lows), 32'd0);
      check("busy0_after_a5", 32'(busy[0]), 32'd0);

      // Five back-to-back writes into a 3-entry FIFO on ch1
      sync_tick();
      wr(3'd1, 8'h01); wr(3'd1, 8'h22); wr(3'd1, 8'h07); wr(3'd1, 8'h80); wr(3'd1, 8'hFF);
      check("full1_set", 32'(fifo_full[1]), 32'd1);
      check("ovf1_set",  32'(overflow[1]),  32'd1);
      check("ovf0_clear", 32'(overflow[0]), 32'd0);
`ifdef PS2_TX_STATS_EN
      check("drop_cnt1_two", 32'(drop_cnt[15:8]), 32'd2);
`endif
      ovf_clear = 1'b1;
      @(negedge clk_sys);
      ovf_clear = 1'b0;
      check("ovf1_cleared", 32'(overflow[1]), 32'd0);
      check("full1_still",  32'(fifo_full[1]), 32'd1);
`ifdef PS2_TX_STATS_EN
      check("drop_cnt1_cleared", 32'(drop_cnt[15:8]), 32'd0);
`endif
      cap(1, f0, f1, span, mis);
      check("frame_01", 32'(f1), 32'h402);
      cap(1, f0, f1, span, mis);
      check("frame_22", 32'(f1), 32'h644);
      cap(1, f0, f1, span, mis);
      check("frame_07", 32'(f1), 32'h40E);
      wait_idle(1);
      check("full1_after", 32'(fifo_full[1]), 32'd0);

      // Host inhibit during D3 of 0x3C on ch0
      wr(3'd0, 8'h3C);
      for (int k = 0; k < 4; k++) next_fall(0, lat);
      for (int n = 0; n < 20; n++) begin @(negedge clk_sys); if (ps2_clk[0]) break; end
      ps2_clk_in[0] = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk_sys);
         if (dut.g_lane[0].u_lane.state == INHIBIT) break;
      end
      check("fsm_inhibit", 32'(dut.g_lane[0].u_lane.state), 32'(INHIBIT));
      check("inhibit_data_high", 32'(ps2_data[0]), 32'd1);
      check("inhibit_not_popped", 32'(busy[0]), 32'd1);
`ifdef PS2_TX_STATS_EN
      check("retx_cnt0_one", 32'(retx_cnt[7:0]), 32'd1);
`endif
      repeat (30) @(negedge clk_sys);
      check("inhibit_clk_high", 32'(ps2_clk[0]), 32'd1);
      ps2_clk_in[0] = 1'b1;
      cap(0, f0, f1, span, mis);
      check("frame_3c_resent", 32'(f0), 32'h678);
      repeat (6) @(negedge clk_sys);
      check("busy0_popped_once", 32'(busy[0]), 32'd0);
      check("full0_after_retx", 32'(fifo_full[0]), 32'd0);

      // Host holds ch1 clock low while a byte is queued
      ps2_clk_in[1] = 1'b0;
      repeat (3) @(negedge clk_sys);
      wr(3'd1, 8'hC3);
      repeat (40) @(negedge clk_sys);
      check("held_no_start", 32'(ps2_data[1]), 32'd1);
      check("held_busy", 32'(busy[1]), 32'd1);
      ps2_clk_in[1] = 1'b1;
      lat = 0;
      while (ps2_data[1] !== 1'b0 && lat < 40) begin @(negedge clk_sys); lat++; end
      check("release_start_le_2ticks", 32'(lat <= 18), 32'd1);
      cap(1, f0, f1, span, mis);
      check("frame_c3", 32'(f1), 32'h786);
      wait_idle(1);

      // Out-of-range channel, then parallel frames on both lanes
      wr(3'd7, 8'hEE);
      repeat (4) @(negedge clk_sys);
      check("chan7_no_busy", 32'(busy), 32'd0);
      check("chan7_no_full", 32'(fifo_full), 32'd0);
      sync_tick();
      wr(3'd0, 8'h5A);
      wr(3'd1, 8'h80);
      cap(0, f0, f1, span, mis);
      check("par_frame_5a", 32'(f0), 32'h6B4);
      check("par_frame_80", 32'(f1), 32'h500);
      check("par_aligned", 32'(mis), 32'd0);
      wait_idle(0);
      wait_idle(1);

      // Flood ch0 with writes
      for (int i = 0; i < 300; i++) wr(3'd0, 8'(i));
      check("flood_ovf0", 32'(overflow[0]), 32'd1);
      check("flood_full0", 32'(fifo_full[0]), 32'd1);
`ifdef PS2_TX_STATS_EN
      check("drop_cnt0_sat", 32'(drop_cnt[7:0]), 32'd255);
`endif

      // Reset mid-frame
      wr(3'd1, 8'hFF);
      lat = 0;
      while (ps2_data[1] !== 1'b0 && lat < 30) begin @(negedge clk_sys); lat++; end
      repeat (10) @(negedge clk_sys);
      reset = 1'b1;
      #1;
      check("midrst_ps2_clk",  32'(ps2_clk),   32'h3);
      check("midrst_ps2_data", 32'(ps2_data),  32'h3);
      check("midrst_full",     32'(fifo_full), 32'h0);
      check("midrst_overflow", 32'(overflow),  32'h0);
      check("midrst_busy",     32'(busy),      32'h0);
`ifdef PS2_TX_STATS_EN
      check("midrst_drop_cnt", 32'(drop_cnt), 32'h0);
      check("midrst_retx_cnt", 32'(retx_cnt), 32'h0);
`endif
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (20) @(negedge clk_sys);
      check("postrst_busy", 32'(busy), 32'h0);
      check("postrst_data", 32'(ps2_data), 32'h3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
